// File: rtl/iecdrv_rom_hub.sv
// iecdrv_rom_hub
//   Shared-ROM front end for up to four C1541 drive cores on one IEC bus.
//   Synchronises the IEC and drive-reset inputs, derives the 1 MHz ph2
//   rise/fall strobes from a 16 MHz enable, hosts a single 32 KB drive ROM
//   with size detection, time-multiplexes ROM reads for every drive within
//   each ph2 cycle, and merges the drives' open-collector IEC and parallel
//   outputs onto single bus outputs.
//
// Ports
//   clk, reset_n         16 MHz clock, synchronous active-low reset
//   ce, pause            16 MHz clock enable, ph2 freeze request
//   drv_reset            per-drive reset (asynchronous to clk)
//   iec_*_i / iec_*_o    raw IEC bus inputs / merged open-collector outputs
//   par_*_i / par_*_o    parallel bus inputs (passed on outside) / merged outputs
//   rom_addr/data/wr     ROM load port
//   ph2_r, ph2_f         single-cycle ph2 edge strobes to the drives
//   drv_rst_s            synchronised drive resets
//   drv_atn/data/clk     bus view given to the drives
//   drv_iec_*, drv_par_* drive outputs to be merged
//   drv_ext_en           per-drive parallel / extended-ROM enable
//   drv_led, led         drive LEDs in, masked by reset out
//   drv_rom_addr/dout    per-drive ROM address (15 bits each) and data (8 each)

module iecdrv_rom_hub #(
    parameter int NDR     = 2,
    parameter int PARPORT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic                 pause,
    input  logic [NDR-1:0]       drv_reset,
    input  logic                 iec_atn_i,
    input  logic                 iec_data_i,
    input  logic                 iec_clk_i,
    output logic                 iec_data_o,
    output logic                 iec_clk_o,
    input  logic [7:0]           par_data_i,
    input  logic                 par_stb_i,
    output logic [7:0]           par_data_o,
    output logic                 par_stb_o,
    input  logic [14:0]          rom_addr,
    input  logic [7:0]           rom_data,
    input  logic                 rom_wr,
    output logic                 ph2_r,
    output logic                 ph2_f,
    output logic [NDR-1:0]       drv_rst_s,
    output logic                 drv_atn,
    output logic                 drv_data,
    output logic                 drv_clk,
    input  logic [NDR-1:0]       drv_iec_data,
    input  logic [NDR-1:0]       drv_iec_clk,
    input  logic [8*NDR-1:0]     drv_par_data,
    input  logic [NDR-1:0]       drv_par_stb,
    output logic [NDR-1:0]       drv_ext_en,
    input  logic [NDR-1:0]       drv_led,
    output logic [NDR-1:0]       led,
    input  logic [15*NDR-1:0]    drv_rom_addr,
    output logic [8*NDR-1:0]     drv_rom_dout
);

    localparam int unsigned ND     = (NDR < 1) ? 1 : ((NDR > 4) ? 4 : NDR);
    localparam bit          PAR_EN = (PARPORT != 0);

    // ------------------------------------------------------------------
    // Input synchronisers (two flops each, idle bus / drives held in reset)
    // ------------------------------------------------------------------
    logic [1:0]     r_atn_s;
    logic [1:0]     r_data_s;
    logic [1:0]     r_clk_s;
    logic [NDR-1:0] r_drst_s0;
    logic [NDR-1:0] r_drst_s1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_atn_s   <= '1;
            r_data_s  <= '1;
            r_clk_s   <= '1;
            r_drst_s0 <= '1;
            r_drst_s1 <= '1;
        end else begin
            r_atn_s   <= {r_atn_s[0],  iec_atn_i};
            r_data_s  <= {r_data_s[0], iec_data_i};
            r_clk_s   <= {r_clk_s[0],  iec_clk_i};
            r_drst_s0 <= drv_reset;
            r_drst_s1 <= r_drst_s0;
        end
    end

    assign drv_rst_s = r_drst_s1;

    // ------------------------------------------------------------------
    // ph2 generator: 16 ce ticks per ph2 period
    // ------------------------------------------------------------------
    logic [3:0] r_div;
    logic       r_ena;
    logic       r_ena1;
    logic       r_ph2_r;
    logic       r_ph2_f;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div   <= '0;
            r_ena   <= 1'b0;
            r_ena1  <= 1'b0;
            r_ph2_r <= 1'b0;
            r_ph2_f <= 1'b0;
        end else begin
            r_ena1 <= ~pause;
            // Only let the pause request through away from a ph2 edge so a
            // strobe is never cut short.
            if (r_div[2:0] != 3'd0) begin
                r_ena <= r_ena1;
            end
            if (ce) begin
                r_div   <= r_div + 4'd1;
                r_ph2_r <= r_ena & ~r_div[3] & (r_div[2:0] == 3'd0);
                r_ph2_f <= r_ena &  r_div[3] & (r_div[2:0] == 3'd0);
            end else begin
                r_ph2_r <= 1'b0;
                r_ph2_f <= 1'b0;
            end
        end
    end

    assign ph2_r = r_ph2_r;
    assign ph2_f = r_ph2_f;

    // ------------------------------------------------------------------
    // ROM size detection
    // ------------------------------------------------------------------
    logic       r_r32;
    logic       r_r16;
    logic       r_empty8k;
    logic [1:0] r_rom_sz;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_r32     <= 1'b1;
            r_r16     <= 1'b1;
            r_empty8k <= 1'b1;
            r_rom_sz  <= 2'b11;
        end else begin
            if (rom_wr) begin
                if (rom_addr == 15'd0) begin
                    r_empty8k <= 1'b1;
                end
                // 00/FF are fill bytes and say nothing about the image size.
                if (rom_data != 8'h00 && rom_data != 8'hFF) begin
                    {r_r32, r_r16} <= rom_addr[14:13];
                    if (rom_addr[14:8] != 7'd0 && rom_addr[14:13] == 2'd0) begin
                        r_empty8k <= 1'b0;
                    end
                end
            end
            r_rom_sz <= {r_r32, r_r32 | r_r16};
        end
    end

    // ------------------------------------------------------------------
    // ROM storage: registered read plus registered output, never reset
    // ------------------------------------------------------------------
    logic [7:0]  r_rom [0:32767];
    logic [14:0] r_mem_a;
    logic [7:0]  r_rd;
    logic [7:0]  r_rd2;

    always_ff @(posedge clk) begin
        if (rom_wr) begin
            r_rom[rom_addr] <= rom_data;
        end
        r_rd  <= r_rom[r_mem_a];
        r_rd2 <= r_rd;
    end

    // ------------------------------------------------------------------
    // Read arbiter: slot k latches drive k's address, data lands in k+3
    // ------------------------------------------------------------------
    logic [2:0] r_state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= 3'd7;
            r_mem_a      <= '0;
            drv_rom_dout <= '0;
        end else begin
            if (r_ph2_f) begin
                r_state <= 3'd0;
            end else if (r_state != 3'd7) begin
                r_state <= r_state + 3'd1;
            end
            for (int unsigned k = 0; k < ND; k++) begin
                // Smaller images mirror: drop address bits above the ROM size.
                if (r_state == 3'(k)) begin
                    r_mem_a <= {drv_rom_addr[15*k+14] & r_rom_sz[1],
                                drv_rom_addr[15*k+13] & r_rom_sz[0],
                                drv_rom_addr[15*k +: 13]};
                end
                if (r_state == 3'(k + 3)) begin
                    drv_rom_dout[8*k +: 8] <= r_rd2;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus merges
    // ------------------------------------------------------------------
    logic           w_iec_data;
    logic           w_iec_clk;
    logic           w_par_stb;
    logic [7:0]     w_par_data;
    logic [NDR-1:0] w_ext_en;

    always_comb begin
        w_iec_data = 1'b1;
        w_iec_clk  = 1'b1;
        w_par_stb  = 1'b1;
        w_par_data = 8'hFF;
        w_ext_en   = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            // A drive in reset releases the open-collector lines.
            w_iec_data  = w_iec_data & (drv_iec_data[i] | r_drst_s1[i]);
            w_iec_clk   = w_iec_clk  & (drv_iec_clk[i]  | r_drst_s1[i]);
            w_ext_en[i] = PAR_EN & r_rom_sz[1] & r_empty8k & ~r_drst_s1[i];
            w_par_stb   = w_par_stb & (drv_par_stb[i] | ~w_ext_en[i]);
            if (w_ext_en[i]) begin
                w_par_data = w_par_data & drv_par_data[8*i +: 8];
            end
        end
    end

    assign iec_data_o = w_iec_data;
    assign iec_clk_o  = w_iec_clk;
    assign drv_atn    = r_atn_s[1];
    assign drv_data   = r_data_s[1] & w_iec_data;
    assign drv_clk    = r_clk_s[1]  & w_iec_clk;
    assign drv_ext_en = w_ext_en;
    assign par_stb_o  = w_par_stb;
    assign par_data_o = w_par_data;
    assign led        = drv_led & ~r_drst_s1;

    // Parallel inputs are routed to the drives outside this block.
    logic w_unused;
    assign w_unused = ^{par_data_i, par_stb_i};

endmodule

// File: tb/tb_iecdrv_rom_hub.sv
// Directed testbench for iecdrv_rom_hub with two drives and the parallel
// port enabled.

module tb_iecdrv_rom_hub;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic        pause;
    logic [1:0]  drv_reset;
    logic        iec_atn_i;
    logic        iec_data_i;
    logic        iec_clk_i;
    logic        iec_data_o;
    logic        iec_clk_o;
    logic [7:0]  par_data_i;
    logic        par_stb_i;
    logic [7:0]  par_data_o;
    logic        par_stb_o;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_wr;
    logic        ph2_r;
    logic        ph2_f;
    logic [1:0]  drv_rst_s;
    logic        drv_atn;
    logic        drv_data;
    logic        drv_clk;
    logic [1:0]  drv_iec_data;
    logic [1:0]  drv_iec_clk;
    logic [15:0] drv_par_data;
    logic [1:0]  drv_par_stb;
    logic [1:0]  drv_ext_en;
    logic [1:0]  drv_led;
    logic [1:0]  led;
    logic [29:0] drv_rom_addr;
    logic [15:0] drv_rom_dout;

    int n_cmp = 0;
    int n_err = 0;

    iecdrv_rom_hub #(.NDR(2), .PARPORT(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce           (ce),
        .pause        (pause),
        .drv_reset    (drv_reset),
        .iec_atn_i    (iec_atn_i),
        .iec_data_i   (iec_data_i),
        .iec_clk_i    (iec_clk_i),
        .iec_data_o   (iec_data_o),
        .iec_clk_o    (iec_clk_o),
        .par_data_i   (par_data_i),
        .par_stb_i    (par_stb_i),
        .par_data_o   (par_data_o),
        .par_stb_o    (par_stb_o),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .rom_wr       (rom_wr),
        .ph2_r        (ph2_r),
        .ph2_f        (ph2_f),
        .drv_rst_s    (drv_rst_s),
        .drv_atn      (drv_atn),
        .drv_data     (drv_data),
        .drv_clk      (drv_clk),
        .drv_iec_data (drv_iec_data),
        .drv_iec_clk  (drv_iec_clk),
        .drv_par_data (drv_par_data),
        .drv_par_stb  (drv_par_stb),
        .drv_ext_en   (drv_ext_en),
        .drv_led      (drv_led),
        .led          (led),
        .drv_rom_addr (drv_rom_addr),
        .drv_rom_dout (drv_rom_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_write(input logic [14:0] a, input logic [7:0] d);
        rom_addr = a;
        rom_data = d;
        rom_wr   = 1'b1;
        tick();
        rom_wr   = 1'b0;
    endtask

    // Returns one sample after the edge that raised ph2_f.
    task automatic wait_ph2f(input string tag);
        int c = 0;
        do begin
            tick();
            c++;
        end while (ph2_f !== 1'b1 && c < 40);
        n_cmp++;
        if (ph2_f !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ph2f_timeout got=%0b exp=1", tag, ph2_f);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ce = 1'b1; pause = 1'b0;
        drv_reset = 2'b11; drv_led = 2'b11;
        drv_iec_data = 2'b00; drv_iec_clk = 2'b00;
        repeat (3) tick();
        n_cmp++; if (ph2_r !== 1'b0) begin n_err++; $display("FAIL rst_ph2_r got=%0b exp=0", ph2_r); end
        n_cmp++; if (ph2_f !== 1'b0) begin n_err++; $display("FAIL rst_ph2_f got=%0b exp=0", ph2_f); end
        n_cmp++; if (iec_data_o !== 1'b1) begin n_err++; $display("FAIL rst_iec_data_o got=%0b exp=1", iec_data_o); end
        n_cmp++; if (iec_clk_o !== 1'b1) begin n_err++; $display("FAIL rst_iec_clk_o got=%0b exp=1", iec_clk_o); end
        n_cmp++; if (par_stb_o !== 1'b1) begin n_err++; $display("FAIL rst_par_stb_o got=%0b exp=1", par_stb_o); end
        n_cmp++; if (par_data_o !== 8'hFF) begin n_err++; $display("FAIL rst_par_data_o got=%h exp=ff", par_data_o); end
        n_cmp++; if (led !== 2'b00) begin n_err++; $display("FAIL rst_led got=%b exp=00", led); end
        n_cmp++; if (drv_ext_en !== 2'b00) begin n_err++; $display("FAIL rst_ext_en got=%b exp=00", drv_ext_en); end
        n_cmp++; if (drv_rst_s !== 2'b11) begin n_err++; $display("FAIL rst_drv_rst_s got=%b exp=11", drv_rst_s); end
        n_cmp++; if (drv_rom_dout !== 16'h0000) begin n_err++; $display("FAIL rst_rom_dout got=%h exp=0000", drv_rom_dout); end
        n_cmp++; if ({drv_atn, drv_data, drv_clk} !== 3'b111) begin n_err++; $display("FAIL rst_drv_bus got=%b exp=111", {drv_atn, drv_data, drv_clk}); end
    endtask

    task automatic test_ph2_rate();
        int nf = 0, nr = 0;
        int f0 = -1, f1 = -1, r0 = -1, r1 = -1;
        reset_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (ph2_f === 1'b1) begin
                if (nf == 0) f0 = c; else if (nf == 1) f1 = c;
                nf++;
            end
            if (ph2_r === 1'b1) begin
                if (nr == 0) r0 = c; else if (nr == 1) r1 = c;
                nr++;
            end
        end
        n_cmp++; if (nf != 2) begin n_err++; $display("FAIL ph2_f_count got=%0d exp=2", nf); end
        n_cmp++; if (nr != 2) begin n_err++; $display("FAIL ph2_r_count got=%0d exp=2", nr); end
        n_cmp++; if (f0 != 9) begin n_err++; $display("FAIL ph2_f_first got=%0d exp=9", f0); end
        n_cmp++; if (f1 != 25) begin n_err++; $display("FAIL ph2_f_second got=%0d exp=25", f1); end
        n_cmp++; if (r0 != 17) begin n_err++; $display("FAIL ph2_r_first got=%0d exp=17", r0); end
        n_cmp++; if (r1 != 33) begin n_err++; $display("FAIL ph2_r_second got=%0d exp=33", r1); end
    endtask

    task automatic test_pause();
        int c = 0;
        int ns = 0;
        do begin tick(); c++; end while (ph2_r !== 1'b1 && c < 40);
        n_cmp++; if (ph2_r !== 1'b1) begin n_err++; $display("FAIL pause_ph2r_timeout got=%0b exp=1", ph2_r); end
        pause = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (ph2_r === 1'b1 || ph2_f === 1'b1) ns++;
        end
        n_cmp++; if (ns != 0) begin n_err++; $display("FAIL pause_strobes got=%0d exp=0", ns); end
        pause = 1'b0; ce = 1'b0; ns = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ph2_r === 1'b1 || ph2_f === 1'b1) ns++;
        end
        n_cmp++; if (ns != 0) begin n_err++; $display("FAIL no_ce_strobes got=%0d exp=0", ns); end
        ce = 1'b1;
        wait_ph2f("resume");
    endtask

    task automatic test_rom32();
        rom_write(15'h7F00, 8'h5A);
        rom_write(15'h7F01, 8'hC3);
        drv_rom_addr = {15'h7F01, 15'h7F00};
        wait_ph2f("rom32a");
        repeat (6) tick();
        n_cmp++; if (drv_rom_dout[7:0] !== 8'h5A) begin n_err++; $display("FAIL rom32_d0 got=%h exp=5a", drv_rom_dout[7:0]); end
        n_cmp++; if (drv_rom_dout[15:8] !== 8'hC3) begin n_err++; $display("FAIL rom32_d1 got=%h exp=c3", drv_rom_dout[15:8]); end
        drv_rom_addr = {15'h7F00, 15'h7F01};
        wait_ph2f("rom32b");
        repeat (4) tick();
        n_cmp++; if (drv_rom_dout[7:0] !== 8'h5A) begin n_err++; $display("FAIL rom32_hold_d0 got=%h exp=5a", drv_rom_dout[7:0]); end
        tick();
        n_cmp++; if (drv_rom_dout[7:0] !== 8'hC3) begin n_err++; $display("FAIL rom32_new_d0 got=%h exp=c3", drv_rom_dout[7:0]); end
        tick();
        n_cmp++; if (drv_rom_dout[15:8] !== 8'h5A) begin n_err++; $display("FAIL rom32_new_d1 got=%h exp=5a", drv_rom_dout[15:8]); end
    endtask

    task automatic test_rom16_collision();
        rom_write(15'h6123, 8'hA5);
        rom_write(15'h2123, 8'h77);
        drv_rom_addr = {15'h2123, 15'h6123};
        wait_ph2f("rom16");
        repeat (6) tick();
        n_cmp++; if (drv_rom_dout[7:0] !== 8'h77) begin n_err++; $display("FAIL rom16_mirror_d0 got=%h exp=77", drv_rom_dout[7:0]); end
        n_cmp++; if (drv_rom_dout[15:8] !== 8'h77) begin n_err++; $display("FAIL rom16_d1 got=%h exp=77", drv_rom_dout[15:8]); end
        // Write lands on the same edge that reads drive 0's address.
        wait_ph2f("collide");
        repeat (2) tick();
        rom_addr = 15'h2123; rom_data = 8'h99; rom_wr = 1'b1;
        tick();
        rom_wr = 1'b0;
        repeat (2) tick();
        n_cmp++; if (drv_rom_dout[7:0] !== 8'h77) begin n_err++; $display("FAIL collide_old_d0 got=%h exp=77", drv_rom_dout[7:0]); end
        tick();
        n_cmp++; if (drv_rom_dout[15:8] !== 8'h99) begin n_err++; $display("FAIL collide_new_d1 got=%h exp=99", drv_rom_dout[15:8]); end
    endtask

    task automatic test_iec();
        drv_reset = 2'b01; drv_iec_data = 2'b01; drv_iec_clk = 2'b11;
        tick();
        n_cmp++; if (iec_data_o !== 1'b1) begin n_err++; $display("FAIL iec_lat1 got=%0b exp=1", iec_data_o); end
        tick();
        n_cmp++; if (iec_data_o !== 1'b0) begin n_err++; $display("FAIL iec_lat2 got=%0b exp=0", iec_data_o); end
        n_cmp++; if (drv_data !== 1'b0) begin n_err++; $display("FAIL iec_drv_data got=%0b exp=0", drv_data); end
        n_cmp++; if (drv_rst_s !== 2'b01) begin n_err++; $display("FAIL iec_rst_s got=%b exp=01", drv_rst_s); end
        drv_iec_data = 2'b10;
        #1;
        n_cmp++; if (iec_data_o !== 1'b1) begin n_err++; $display("FAIL iec_rst_mask got=%0b exp=1", iec_data_o); end
        drv_iec_clk = 2'b01;
        #1;
        n_cmp++; if ({iec_clk_o, drv_clk} !== 2'b00) begin n_err++; $display("FAIL iec_clk got=%b exp=00", {iec_clk_o, drv_clk}); end
        drv_iec_clk = 2'b11; drv_iec_data = 2'b11; iec_data_i = 1'b0;
        tick();
        n_cmp++; if (drv_data !== 1'b1) begin n_err++; $display("FAIL data_in_lat1 got=%0b exp=1", drv_data); end
        tick();
        n_cmp++; if (drv_data !== 1'b0) begin n_err++; $display("FAIL data_in_lat2 got=%0b exp=0", drv_data); end
        iec_atn_i = 1'b0;
        repeat (2) tick();
        n_cmp++; if (drv_atn !== 1'b0) begin n_err++; $display("FAIL atn_in got=%0b exp=0", drv_atn); end
        iec_atn_i = 1'b1; iec_data_i = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_led();
        drv_led = 2'b11;
        #1;
        n_cmp++; if (led !== 2'b10) begin n_err++; $display("FAIL led_a got=%b exp=10", led); end
        drv_reset = 2'b10;
        tick();
        n_cmp++; if (led !== 2'b10) begin n_err++; $display("FAIL led_lat1 got=%b exp=10", led); end
        tick();
        n_cmp++; if (led !== 2'b01) begin n_err++; $display("FAIL led_lat2 got=%b exp=01", led); end
    endtask

    task automatic test_parallel();
        drv_reset = 2'b00;
        rom_write(15'h7F00, 8'h5A);
        repeat (2) tick();
        n_cmp++; if (drv_ext_en !== 2'b11) begin n_err++; $display("FAIL par_ext_en got=%b exp=11", drv_ext_en); end
        drv_par_data = {8'h3C, 8'hF0}; drv_par_stb = 2'b01;
        #1;
        n_cmp++; if (par_data_o !== 8'h30) begin n_err++; $display("FAIL par_data_and got=%h exp=30", par_data_o); end
        n_cmp++; if (par_stb_o !== 1'b0) begin n_err++; $display("FAIL par_stb_low got=%0b exp=0", par_stb_o); end
        drv_par_stb = 2'b11;
        #1;
        n_cmp++; if (par_stb_o !== 1'b1) begin n_err++; $display("FAIL par_stb_high got=%0b exp=1", par_stb_o); end
        drv_reset = 2'b10; drv_par_stb = 2'b01;
        repeat (2) tick();
        n_cmp++; if (drv_ext_en !== 2'b01) begin n_err++; $display("FAIL par_one_en got=%b exp=01", drv_ext_en); end
        n_cmp++; if (par_data_o !== 8'hF0) begin n_err++; $display("FAIL par_one_data got=%h exp=f0", par_data_o); end
        n_cmp++; if (par_stb_o !== 1'b1) begin n_err++; $display("FAIL par_one_stb got=%0b exp=1", par_stb_o); end
        rom_write(15'h0100, 8'h12);
        tick();
        n_cmp++; if (drv_ext_en !== 2'b00) begin n_err++; $display("FAIL par_8k_used got=%b exp=00", drv_ext_en); end
        n_cmp++; if (par_data_o !== 8'hFF) begin n_err++; $display("FAIL par_none_data got=%h exp=ff", par_data_o); end
        rom_write(15'h0000, 8'h00);
        tick();
        n_cmp++; if (drv_ext_en !== 2'b00) begin n_err++; $display("FAIL par_size_small got=%b exp=00", drv_ext_en); end
        rom_write(15'h7F00, 8'h5A);
        tick();
        n_cmp++; if (drv_ext_en !== 2'b01) begin n_err++; $display("FAIL par_restored got=%b exp=01", drv_ext_en); end
    endtask

    task automatic test_reset_mid();
        int ns = 0;
        drv_rom_addr = {15'h7F00, 15'h7F00};
        wait_ph2f("mid_pre");
        repeat (6) tick();
        n_cmp++; if (drv_rom_dout !== 16'h5A5A) begin n_err++; $display("FAIL mid_pre_dout got=%h exp=5a5a", drv_rom_dout); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_cmp++; if (drv_rom_dout !== 16'h0000) begin n_err++; $display("FAIL mid_rst_dout got=%h exp=0000", drv_rom_dout); end
        n_cmp++; if (drv_rst_s !== 2'b11) begin n_err++; $display("FAIL mid_rst_s got=%b exp=11", drv_rst_s); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ph2_r === 1'b1 || ph2_f === 1'b1) ns++;
        end
        n_cmp++; if (ns != 0) begin n_err++; $display("FAIL mid_early_strobe got=%0d exp=0", ns); end
        n_cmp++; if (drv_rom_dout !== 16'h0000) begin n_err++; $display("FAIL mid_idle_dout got=%h exp=0000", drv_rom_dout); end
        wait_ph2f("mid_post");
        repeat (5) tick();
        n_cmp++; if (drv_rom_dout[7:0] !== 8'h5A) begin n_err++; $display("FAIL mid_rom_kept got=%h exp=5a", drv_rom_dout[7:0]); end
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b1; pause = 1'b0;
        drv_reset = 2'b11;
        iec_atn_i = 1'b1; iec_data_i = 1'b1; iec_clk_i = 1'b1;
        par_data_i = 8'hFF; par_stb_i = 1'b1;
        rom_addr = '0; rom_data = '0; rom_wr = 1'b0;
        drv_iec_data = 2'b11; drv_iec_clk = 2'b11;
        drv_par_data = 16'hFFFF; drv_par_stb = 2'b11;
        drv_led = 2'b00; drv_rom_addr = '0;

        test_reset();
        test_ph2_rate();
        test_pause();
        test_rom32();
        test_rom16_collision();
        test_iec();
        test_led();
        test_parallel();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
